// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Serializes WIDTH-bit parallel words into a registered bit stream for a
//   downstream pattern detector. The stream is qualified by enable. Every
//   enable=0 cycle drives serial_pattern=0, so the detector can clear its
//   history on those cycles.
//
//   Optional feature: define PATTERN_SERIALIZER_PREFETCH_EN to add a one-word
//   holding register. Words then stream back-to-back with no gap cycle.
//   Without it, consecutive words are separated by exactly one idle cycle.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
// Ports
//   clk, rst        clock and synchronous active-high reset
//   par_data        parallel word, sampled only on an accepted handshake
//   par_valid       upstream has a word
//   par_ready       block can accept a word this cycle (0 while rst=1)
//   serial_pattern  registered serial bit
//   enable          registered: serial_pattern carries a valid bit
//   word_done       registered: high together with the last bit of a word
//   busy            shifting, or the holding register is full
module pattern_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             serial_pattern,
  output logic             enable,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             accept, last_bit;

`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  // Handshake is combinational. Reset masks it, so a word offered during
  // reset is never taken.
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  assign par_ready = !rst && ((state_q == IDLE) || !hold_full_q);
  assign busy      = (state_q == SHIFT) || hold_full_q;
`else
  assign par_ready = !rst && (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
`endif

  assign accept   = par_valid && par_ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = par_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        en_d   = 1'b1;
        done_d = last_bit;
        if (MSB_FIRST) begin
          ser_d = sr_q[WIDTH-1];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end else begin
          ser_d = sr_q[0];
          sr_d  = {1'b0, sr_q[WIDTH-1:1]};
        end
        if (last_bit) begin
          cnt_d = '0;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
          // Reload on the last-bit edge so the next word starts with no gap.
          // A held word takes precedence over the word offered on par_data.
          if (hold_full_q) begin
            sr_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sr_d = par_data;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
          if (accept) begin
            hold_d      = par_data;
            hold_full_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign serial_pattern = ser_q;
  assign enable         = en_q;
  assign word_done      = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer. Two instances (MSB-first and LSB-first) share
// the same inputs. The reference model is a timeline. Each accepted word books
// its WIDTH output bits against future clock-edge numbers. Any edge with no
// booking must show enable=0, serial_pattern=0 and word_done=0.
module tb_pattern_serializer;
  localparam int W = 8;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pv  = 1'b0;
  logic [W-1:0] pd  = '0;
  logic rdy_m, ser_m, en_m, done_m, busy_m;
  logic rdy_l, ser_l, en_l, done_l, busy_l;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .par_data(pd), .par_valid(pv), .par_ready(rdy_m),
    .serial_pattern(ser_m), .enable(en_m), .word_done(done_m), .busy(busy_m));

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .par_data(pd), .par_valid(pv), .par_ready(rdy_l),
    .serial_pattern(ser_l), .enable(en_l), .word_done(done_l), .busy(busy_l));

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  // Edge on which the newest word starts shifting, and edge of its last bit.
  int lstart = -100;
  int llast  = -100;
  bit exp_en[int];
  bit exp_bm[int];
  bit exp_bl[int];
  bit exp_dn[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  // Without prefetch a word is taken only once the previous one has ended.
  // With prefetch a word is taken unless one is already waiting to start.
  function automatic bit model_ready(input int e);
    return PF ? (lstart < e) : (llast < e);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output bit acc);
    bit rd;
    int s;
    rst = r; pv = v; pd = d;
    #1;
    rd = !r && model_ready(edge_n + 1);
    chk("par_ready_msb", rdy_m, rd);
    chk("par_ready_lsb", rdy_l, rd);
    acc = v && rd;
    @(posedge clk);
    edge_n++;
    if (r) begin
      for (int k = edge_n; k < edge_n + 4 * W; k++) begin
        exp_en.delete(k); exp_bm.delete(k); exp_bl.delete(k); exp_dn.delete(k);
      end
      lstart = edge_n - 1;
      llast  = edge_n - 1;
    end else if (acc) begin
      s = (llast > edge_n) ? llast : edge_n;
      for (int i = 0; i < W; i++) begin
        exp_en[s + 1 + i] = 1'b1;
        exp_bm[s + 1 + i] = d[W-1-i];
        exp_bl[s + 1 + i] = d[i];
        exp_dn[s + 1 + i] = (i == W - 1);
      end
      lstart = s;
      llast  = s + W;
    end
    #1;
    chk("enable_msb", en_m, exp_en.exists(edge_n) ? exp_en[edge_n] : 1'b0);
    chk("enable_lsb", en_l, exp_en.exists(edge_n) ? exp_en[edge_n] : 1'b0);
    chk("serial_msb", ser_m, exp_bm.exists(edge_n) ? exp_bm[edge_n] : 1'b0);
    chk("serial_lsb", ser_l, exp_bl.exists(edge_n) ? exp_bl[edge_n] : 1'b0);
    chk("word_done_msb", done_m, exp_dn.exists(edge_n) ? exp_dn[edge_n] : 1'b0);
    chk("word_done_lsb", done_l, exp_dn.exists(edge_n) ? exp_dn[edge_n] : 1'b0);
    chk("busy", busy_m, edge_n < llast);
    @(negedge clk);
  endtask

  // Idle cycles. par_data keeps changing to show it is ignored while par_valid=0.
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, acc);
  endtask

  // Hold par_valid until the word is taken, within a bounded number of cycles.
  task automatic send(input logic [W-1:0] d);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 4 * W) begin
      step(1'b1, d, 1'b0, acc);
      tries++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $error("FAIL send_timeout: word %0h not accepted within %0d cycles", d, tries);
    end
  endtask

  initial begin
    bit acc;
    // Reset, including a word offered during reset that must not be taken.
    step(1'b0, '0, 1'b1, acc);
    step(1'b1, 8'h77, 1'b1, acc);
    chk("busy_after_reset", busy_l, 1'b0);
    // 0xB4: MSB stream 1,0,1,1,0,1,0,0. 0x01: LSB stream 1 then seven 0s.
    send(8'hB4);
    idle(W + 2);
    send(8'h01);
    idle(W + 2);
    // Continuous valid: 0xFF then 0x00 (gap depends on prefetch).
    send(8'hFF);
    send(8'h00);
    idle(2 * W + 2);
    // Reset after bit 3 of 0xA5, then a clean 0x3C.
    send(8'hA5);
    idle(3);
    step(1'b0, 8'h5A, 1'b1, acc);
    idle(2);
    send(8'h3C);
    idle(W + 2);
    // par_valid held high with par_data toggling every cycle.
    for (int i = 0; i < 60; i++) step(1'b1, W'($urandom), 1'b0, acc);
    idle(2 * W + 2);
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 59) == 0, acc);
    idle(2 * W + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
